// File: rtl/tick_timebase_if.sv
// Control/status bundle between a timebase and whatever drives it (time-setting
// logic, alarm compare, or the next cascaded timebase).
interface tick_timebase_if #(
    parameter int CNT_W = 10
);
    logic             en;
    logic             clr;
    logic             load;
    logic [CNT_W-1:0] load_val;
    logic             tick;
    logic [CNT_W-1:0] count;
    logic             wrap;
    logic             running;

    modport master (
        output en, clr, load, load_val,
        input  tick, count, wrap, running
    );

    modport slave (
        input  en, clr, load, load_val,
        output tick, count, wrap, running
    );
endinterface

// File: rtl/tick_timebase.sv
// Clock prescaler producing a one-cycle tick every CLK_HZ/TICK_HZ enabled cycles,
// plus a modulo-CNT_MOD tick counter whose wrap pulse feeds the next stage.
module tick_timebase #(
    parameter int CLK_HZ  = 10_000_000,
    parameter int TICK_HZ = 1_000,
    parameter int CNT_MOD = 1000,
    parameter int CNT_W   = 10
) (
    input  logic          clk,
    input  logic          reset,
    tick_timebase_if.slave bus
);
    localparam int DIV   = CLK_HZ / TICK_HZ;
    localparam int PRE_W = $clog2(DIV);

    localparam logic [PRE_W-1:0] PRE_MAX  = PRE_W'(DIV - 1);
    localparam logic [PRE_W-1:0] PRE_ZERO = {PRE_W{1'b0}};
    localparam logic [PRE_W-1:0] PRE_ONE  = PRE_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(CNT_MOD - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [0:0] {
        ST_STOP = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    state_e           state_q;
    logic             running_q;
    logic [PRE_W-1:0] pre_q;
    logic [PRE_W-1:0] pre_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             tick_q;
    logic             tick_d;
    logic             wrap_q;
    logic             wrap_d;

    // Time-setting values above the modulus are clamped rather than rejected.
    function automatic logic [CNT_W-1:0] sat_count(input logic [CNT_W-1:0] v);
        if (v > CNT_MAX) begin
            return CNT_MAX;
        end else begin
            return v;
        end
    endfunction

    // Run/stop state tracks en with one cycle of lag; clr/load leave it alone.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_STOP;
            running_q <= 1'b0;
        end else begin
            case (state_q)
                ST_STOP: begin
                    if (bus.en) begin
                        state_q   <= ST_RUN;
                        running_q <= 1'b1;
                    end else begin
                        state_q   <= ST_STOP;
                        running_q <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (!bus.en) begin
                        state_q   <= ST_STOP;
                        running_q <= 1'b0;
                    end else begin
                        state_q   <= ST_RUN;
                        running_q <= 1'b1;
                    end
                end
                default: begin
                    state_q   <= ST_STOP;
                    running_q <= 1'b0;
                end
            endcase
        end
    end

    // Next-state for prescaler and counter; clr beats load beats the tick event.
    always_comb begin
        pre_d  = pre_q;
        cnt_d  = cnt_q;
        tick_d = 1'b0;
        wrap_d = 1'b0;
        if (bus.clr) begin
            pre_d = PRE_ZERO;
            cnt_d = CNT_ZERO;
        end else if (bus.load) begin
            pre_d = PRE_ZERO;
            cnt_d = sat_count(bus.load_val);
        end else if (bus.en) begin
            // >= rather than == so a corrupted register recovers in one period.
            if (pre_q >= PRE_MAX) begin
                pre_d  = PRE_ZERO;
                tick_d = 1'b1;
                if (cnt_q >= CNT_MAX) begin
                    cnt_d  = CNT_ZERO;
                    wrap_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end else begin
                pre_d = pre_q + PRE_ONE;
            end
        end else begin
            pre_d = pre_q;
        end
    end

    // Datapath registers; tick and wrap are single-cycle registered pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            pre_q  <= PRE_ZERO;
            cnt_q  <= CNT_ZERO;
            tick_q <= 1'b0;
            wrap_q <= 1'b0;
        end else begin
            pre_q  <= pre_d;
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
            wrap_q <= wrap_d;
        end
    end

    assign bus.tick    = tick_q;
    assign bus.count   = cnt_q;
    assign bus.wrap    = wrap_q;
    assign bus.running = running_q;

endmodule
